rx_frame_writer: RTL
====================

// Module: rx_frame_writer
// PURPOSE
// - Upstream of the VGA TX stage. Samples the HP instrument's 1-bit video with its HSYNC/VSYNC, then writes one
//   8-bit grey byte per source pixel into the frame BRAM, row-major from address 0.
// - Emits VGA_SYNC, a one-cycle pulse at each source frame start. It drives the TX/VGA_CONTROL SYNC input so both frames stay locked.
// PARAMETERS
// - H_PIXELS     128    source pixels stored per line
// - V_LINES      120    source lines stored per frame (H_PIXELS*V_LINES <= 16384)
// - H_OFFSET     40     CLK cycles from HSYNC leading edge to first sample point
// - SAMPLE_DIV   4      CLK cycles per source pixel (>=2)
// - V_OFFSET     2      lines skipped after VSYNC before first stored line
// - FG_LEVEL     8'hFF  byte written when video sample is 1
// - BG_LEVEL     8'h00  byte written when video sample is 0
// - SYNC_POL     1'b1   active level of HP_HSYNC/HP_VSYNC
// PORTS
// - CLK          in   1   system/pixel clock; all logic on rising edge
// - RESET        in   1   synchronous, active-high reset
// - ENABLE       in   1   0 = hold state, no BRAM writes
// - HP_VIDEO     in   1   async source video
// - HP_HSYNC     in   1   async source line sync
// - HP_VSYNC     in   1   async source frame sync
// - BRAM_ADDR    out  14  write address
// - BRAM_DIN     out  8   write data
// - BRAM_WE      out  1   write strobe, one cycle per pixel
// - VGA_SYNC     out  1   one-cycle frame-start pulse to TX
// - FRAME_DONE   out  1   one-cycle pulse after last pixel of a complete frame
// - LOCKED       out  1   high after 2 consecutive complete frames; cleared by a short frame
// BEHAVIOUR
// - Reset:
//   - All outputs 0.
//   - FSM = WAIT_VS; counters 0.
//   - Synchroniser flops cleared.
// - Sync inputs:
//   - All three HP inputs pass through 2-FF synchronisers, then 1 reg for edge detect.
//   - Fixed 3-cycle input latency.
// - FSM states:
//   - WAIT_VS: on VSYNC leading edge -> VGA_SYNC=1 for one cycle, line_cnt=0, BRAM_ADDR=0 -> WAIT_HS.
//   - WAIT_HS: on HSYNC leading edge -> if line_cnt < V_OFFSET, increment line_cnt and stay; else -> H_DELAY with cyc=0.
//   - H_DELAY: count H_OFFSET cycles -> ACTIVE with pix_cnt=0, div=0.
//   - ACTIVE:
//     - On div == SAMPLE_DIV/2: sample synced video; next cycle BRAM_WE=1, BRAM_DIN = sample ? FG_LEVEL : BG_LEVEL.
//     - BRAM_ADDR holds the current pixel address during the WE cycle, then increments.
//     - div wraps at SAMPLE_DIV-1.
//     - After H_PIXELS writes -> LINE_END.
//   - LINE_END: stored_lines += 1. If stored_lines == V_LINES -> FRAME_DONE pulse -> WAIT_VS; else -> WAIT_HS.
// - Address arithmetic:
//   - 14-bit; never exceeds H_PIXELS*V_LINES-1.
//   - Lines beyond V_LINES are ignored until the next VSYNC.
// - VSYNC leading edge in any state other than WAIT_VS:
//   - Frame is aborted; LOCKED=0; no FRAME_DONE.
//   - Treated as a new frame start (VGA_SYNC pulse, address 0) in the same cycle.
// - HSYNC leading edge during H_DELAY/ACTIVE:
//   - Line truncated; remaining pixels not written.
//   - Still counts as a stored line; restart H_DELAY for next line.
// - ENABLE=0: FSM and counters freeze; BRAM_WE forced 0; edge detectors keep running, so edges during freeze are lost.
// - RESET mid-write: WE drops the same cycle RESET is sampled; partial frame left in BRAM.
// - LOCKED:
//   - 2-bit saturating count of consecutive FRAME_DONE; LOCKED = count==2.
//   - Abort clears count.
// STRUCTURE
// - hp2vga_pkg: FSM state localparams (WAIT_VS, WAIT_HS, H_DELAY, ACTIVE, LINE_END), BRAM_AW=14, PIX_W=8.
// - Sub-module sync_edge (2-FF sync + rise-edge detect, SYNC_POL aware): instantiated 3x; video uses sync output only.
// - Remainder is one always block: FSM + counters.
// TESTING
// - Reset then H=4, V=2, SAMPLE_DIV=4, alternating video -> 8 writes, addr 0..7, data FF,00,FF,00...; FRAME_DONE once.
// - VSYNC edge -> VGA_SYNC high exactly 1 cycle, 3 cycles after pin edge; BRAM_ADDR=0.
// - VSYNC mid-line 1 -> abort, no FRAME_DONE, LOCKED=0, next write at addr 0.
// - Source sends V_LINES+5 lines -> last write addr = H*V-1, no further WE until VSYNC.
// - Early HSYNC after 2 of 4 pixels -> next line's first write at addr 4, not 2.
// - Two clean frames -> LOCKED=1; ENABLE=0 for 50 cycles mid-line -> zero WE, resumes same addr.

Source files
------------

// File: rtl/hp2vga_pkg.sv
// Shared types and widths for the HP-instrument capture path feeding the VGA TX stage.
package hp2vga_pkg;

  localparam int BRAM_AW = 14;
  localparam int PIX_W   = 8;

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_HS,
    H_DELAY,
    ACTIVE,
    LINE_END
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous HP input, plus a leading-edge detector
// that honours the configured active level.
module sync_edge #(
  parameter logic SYNC_POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_active;

  assign w_active = (r_sync == SYNC_POL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      // Match the cleared synchroniser so leaving reset never looks like an edge.
      r_prev <= (1'b0 == SYNC_POL);
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= w_active;
    end
  end

  assign o_level = w_active;
  assign o_rise  = w_active & ~r_prev;

endmodule

// File: rtl/rx_frame_writer.sv
// Captures the HP instrument's 1-bit video into the frame BRAM, one grey byte per source
// pixel, row-major from address 0, and emits the frame-start pulse that locks the VGA TX.
module rx_frame_writer
  import hp2vga_pkg::*;
#(
  parameter int               H_PIXELS   = 128,
  parameter int               V_LINES    = 120,
  parameter int               H_OFFSET   = 40,
  parameter int               SAMPLE_DIV = 4,
  parameter int               V_OFFSET   = 2,
  parameter logic [PIX_W-1:0] FG_LEVEL   = 8'hFF,
  parameter logic [PIX_W-1:0] BG_LEVEL   = 8'h00,
  parameter logic             SYNC_POL   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_hp_video,
  input  logic               i_hp_hsync,
  input  logic               i_hp_vsync,
  output logic [BRAM_AW-1:0] o_bram_addr,
  output logic [PIX_W-1:0]   o_bram_din,
  output logic               o_bram_we,
  output logic               o_vga_sync,
  output logic               o_frame_done,
  output logic               o_locked
);

  localparam int PCW = cnt_w(H_PIXELS);
  localparam int OCW = cnt_w(V_OFFSET + 1);
  localparam int SCW = cnt_w(V_LINES + 1);
  localparam int CCW = cnt_w(H_OFFSET);
  localparam int DCW = cnt_w(SAMPLE_DIV);

  logic w_video, w_video_rise_unused, w_hs_rise, w_vs_rise, w_hs_level_unused, w_vs_level_unused;

  sync_edge #(.SYNC_POL(1'b1)) u_sync_video (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_hp_video),
    .o_level(w_video), .o_rise(w_video_rise_unused)
  );
  sync_edge #(.SYNC_POL(SYNC_POL)) u_sync_hsync (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_hp_hsync),
    .o_level(w_hs_level_unused), .o_rise(w_hs_rise)
  );
  sync_edge #(.SYNC_POL(SYNC_POL)) u_sync_vsync (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_hp_vsync),
    .o_level(w_vs_level_unused), .o_rise(w_vs_rise)
  );

  state_e             r_state, w_state_nx;
  logic [OCW-1:0]     r_line_cnt, w_line_cnt_nx;
  logic [SCW-1:0]     r_stored, w_stored_nx;
  logic [CCW-1:0]     r_cyc, w_cyc_nx;
  logic [PCW-1:0]     r_pix_cnt, w_pix_cnt_nx;
  logic [DCW-1:0]     r_div, w_div_nx;
  logic [BRAM_AW-1:0] r_addr, w_addr_nx;
  logic [PIX_W-1:0]   r_din, w_din_nx;
  logic [1:0]         r_lock_cnt, w_lock_cnt_nx;
  logic               r_we, w_we_nx, r_vga_sync, w_vga_sync_nx, r_frame_done, w_frame_done_nx;
  logic               w_end_line, w_last_line;
  logic [SCW-1:0]     w_lines_inc;
  logic [BRAM_AW-1:0] w_line_base;

  assign w_lines_inc = r_stored + 1'b1;
  assign w_last_line = (int'(w_lines_inc) == V_LINES);
  assign w_line_base = BRAM_AW'(int'(w_lines_inc) * H_PIXELS);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx      = r_state;
    w_line_cnt_nx   = r_line_cnt;
    w_stored_nx     = r_stored;
    w_cyc_nx        = r_cyc;
    w_pix_cnt_nx    = r_pix_cnt;
    w_div_nx        = r_div;
    w_addr_nx       = r_addr;
    w_din_nx        = r_din;
    w_lock_cnt_nx   = r_lock_cnt;
    w_we_nx         = 1'b0;
    w_vga_sync_nx   = 1'b0;
    w_frame_done_nx = 1'b0;
    w_end_line      = 1'b0;

    if (!i_enable) begin
      // Full freeze: a pending strobe is held and replayed once enable returns.
      w_we_nx         = r_we;
      w_vga_sync_nx   = r_vga_sync;
      w_frame_done_nx = r_frame_done;
    end else if (w_vs_rise) begin
      if (r_state != WAIT_VS) w_lock_cnt_nx = 2'd0;
      w_vga_sync_nx = 1'b1;
      w_addr_nx     = '0;
      w_line_cnt_nx = '0;
      w_stored_nx   = '0;
      w_state_nx    = WAIT_HS;
    end else begin
      if (r_we && r_state == ACTIVE) w_addr_nx = r_addr + 1'b1;
      case (r_state)
        WAIT_VS: ;
        WAIT_HS: begin
          if (w_hs_rise) begin
            if (int'(r_line_cnt) < V_OFFSET) begin
              w_line_cnt_nx = r_line_cnt + 1'b1;
            end else begin
              w_state_nx = H_DELAY;
              w_cyc_nx   = '0;
            end
          end
        end
        H_DELAY: begin
          if (w_hs_rise) begin
            w_end_line = 1'b1;
          end else if (int'(r_cyc) == H_OFFSET - 1) begin
            w_state_nx   = ACTIVE;
            w_pix_cnt_nx = '0;
            w_div_nx     = '0;
          end else begin
            w_cyc_nx = r_cyc + 1'b1;
          end
        end
        ACTIVE: begin
          if (w_hs_rise) begin
            w_end_line = 1'b1;
          end else begin
            if (int'(r_div) == SAMPLE_DIV / 2) begin
              w_we_nx      = 1'b1;
              w_din_nx     = w_video ? FG_LEVEL : BG_LEVEL;
              w_pix_cnt_nx = r_pix_cnt + 1'b1;
              if (int'(r_pix_cnt) == H_PIXELS - 1) w_state_nx = LINE_END;
            end
            w_div_nx = (int'(r_div) == SAMPLE_DIV - 1) ? '0 : r_div + 1'b1;
          end
        end
        LINE_END: w_end_line = 1'b1;
        default:  w_state_nx = WAIT_VS;
      endcase

      // A truncated line still counts as stored; the next line starts on its own row.
      if (w_end_line) begin
        w_stored_nx = w_lines_inc;
        if (w_last_line) begin
          w_frame_done_nx = 1'b1;
          w_state_nx      = WAIT_VS;
          if (r_lock_cnt != 2'd2) w_lock_cnt_nx = r_lock_cnt + 1'b1;
        end else begin
          w_addr_nx  = w_line_base;
          w_state_nx = (r_state == LINE_END) ? WAIT_HS : H_DELAY;
          w_cyc_nx   = '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= WAIT_VS;
      r_line_cnt   <= '0;
      r_stored     <= '0;
      r_cyc        <= '0;
      r_pix_cnt    <= '0;
      r_div        <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_lock_cnt   <= 2'd0;
      r_we         <= 1'b0;
      r_vga_sync   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_line_cnt   <= w_line_cnt_nx;
      r_stored     <= w_stored_nx;
      r_cyc        <= w_cyc_nx;
      r_pix_cnt    <= w_pix_cnt_nx;
      r_div        <= w_div_nx;
      r_addr       <= w_addr_nx;
      r_din        <= w_din_nx;
      r_lock_cnt   <= w_lock_cnt_nx;
      r_we         <= w_we_nx;
      r_vga_sync   <= w_vga_sync_nx;
      r_frame_done <= w_frame_done_nx;
    end
  end

  assign o_bram_addr  = r_addr;
  assign o_bram_din   = r_din;
  assign o_bram_we    = r_we & i_enable;
  assign o_vga_sync   = r_vga_sync & i_enable;
  assign o_frame_done = r_frame_done & i_enable;
  assign o_locked     = (r_lock_cnt == 2'd2);

endmodule
